regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp.sv | 135 +++++++++++++
 tb/tb_regfile_mp.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with a background clear sweep.
// Entry 0 is hardwired to zero. Optional write-first read bypass is compiled
// in when the REGFILE_BYPASS_EN macro is defined; the default build has none.
// Handshake: no valid/ready pairs here. A write is accepted on a rising edge
// when we=1, busy=0 and waddr!=0. A write offered while busy=1 is dropped and
// reported by a one-cycle wr_drop pulse. clr_req is sampled only in IDLE.
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREAD  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [NREAD*ADDR_W-1:0]  raddr,
  output logic [NREAD*DATA_W-1:0]  rdata,
  input  logic                     clr_req,
  output logic                     busy,
  output logic                     clr_done,
  output logic                     wr_drop
);

  localparam int N = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] ptr_next;
  logic              wr_en;
  logic              sweep_end;
  logic [DATA_W-1:0] mem [N];

  // State register: FSM state and sweep pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  // Next-state logic: the pointer stops at the last entry rather than wrapping.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_next = CLEAR;
          ptr_next   = '0;
        end
      end
      CLEAR: begin
        if (ptr == LAST_ADDR) begin
          state_next = IDLE;
        end else begin
          ptr_next = ptr + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        ptr_next   = '0;
      end
    endcase
  end

  // Output logic: busy is the CLEAR state itself; writes only land when idle.
  always_comb begin
    busy      = (state == CLEAR);
    wr_en     = we && (state == IDLE) && (waddr != '0);
    sweep_end = (state == CLEAR) && (ptr == LAST_ADDR);
  end

  // Status pulses: each is high for the single cycle after its triggering edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clr_done <= 1'b0;
      wr_drop  <= 1'b0;
    end else begin
      clr_done <= sweep_end;
      wr_drop  <= we && (state == CLEAR);
    end
  end

  // Storage: normal writes in IDLE, one entry zeroed per cycle in CLEAR.
  // A write coinciding with clr_req lands first and is then swept like the rest.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        mem[waddr] <= wdata;
      end
      if (state == CLEAR) begin
        mem[ptr] <= '0;
      end
    end
  end

  // Read ports: independent combinational muxes, entry 0 forced to zero.
  for (genvar p = 0; p < NREAD; p++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;

    assign ra = raddr[p*ADDR_W +: ADDR_W];

    // Per-port read mux with optional same-cycle write-first bypass.
    always_comb begin
      rd = mem[ra];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && (ra == waddr)) begin
        rd = wdata;
      end
`endif
      if (ra == '0) begin
        rd = '0;
      end
    end

    assign rdata[p*DATA_W +: DATA_W] = rd;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized and directed checks of regfile_mp against an
// array-based reference model. A second, narrower instance exercises four
// independent read ports.
module tb_regfile_mp;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int NR  = 2;
  localparam int N   = 32;
  localparam int DW4 = 16;
  localparam int AW4 = 3;
  localparam int NR4 = 4;

  // Clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Default-parameter instance signals
  logic             we;
  logic [AW-1:0]    waddr;
  logic [DW-1:0]    wdata;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic             clr_req;
  logic             busy;
  logic             clr_done;
  logic             wr_drop;

  // Four-port instance signals
  logic               we4;
  logic [AW4-1:0]     waddr4;
  logic [DW4-1:0]     wdata4;
  logic [NR4*AW4-1:0] raddr4;
  logic [NR4*DW4-1:0] rdata4;
  logic               clr_req4;
  logic               busy4;
  logic               clr_done4;
  logic               wr_drop4;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR)) dut (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata), .clr_req(clr_req), .busy(busy),
    .clr_done(clr_done), .wr_drop(wr_drop)
  );

  regfile_mp #(.DATA_W(DW4), .ADDR_W(AW4), .NREAD(NR4)) dut4 (
    .clk(clk), .reset(reset), .we(we4), .waddr(waddr4), .wdata(wdata4),
    .raddr(raddr4), .rdata(rdata4), .clr_req(clr_req4), .busy(busy4),
    .clr_done(clr_done4), .wr_drop(wr_drop4)
  );

  int total = 0;
  int bad   = 0;

  // Reference model
  logic [DW-1:0]  m_mem [N];
  logic [DW4-1:0] m4 [8];
  bit             m_busy;
  int             m_idx;
  bit             m_done;
  bit             m_drop;

  function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a);
    if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (we && !m_busy && waddr != 0 && a == waddr) return wdata;
`endif
    return m_mem[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_mem[i] = '0;
    for (int i = 0; i < 8; i++) m4[i] = '0;
    m_busy = 0;
    m_idx  = 0;
    m_done = 0;
    m_drop = 0;
  endtask

  // Apply the effect of one rising edge using the inputs held across it.
  task automatic model_edge();
    if (m_busy) begin
      m_drop = we;
      m_done = 0;
      m_mem[m_idx] = '0;
      m_idx++;
      if (m_idx == N) begin
        m_busy = 0;
        m_done = 1;
      end
    end else begin
      m_drop = 0;
      m_done = 0;
      if (we && waddr != 0) m_mem[waddr] = wdata;
      if (clr_req) begin
        m_busy = 1;
        m_idx  = 0;
      end
    end
    if (we4 && waddr4 != 0) m4[waddr4] = wdata4;
  endtask

  // Driver: advance one edge, update model, check status outputs.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    total++;
    if (busy !== m_busy) begin
      bad++;
      $display("FAIL busy: got %0b want %0b at %0t", busy, m_busy, $time);
    end
    total++;
    if (clr_done !== m_done) begin
      bad++;
      $display("FAIL clr_done: got %0b want %0b at %0t", clr_done, m_done, $time);
    end
    total++;
    if (wr_drop !== m_drop) begin
      bad++;
      $display("FAIL wr_drop: got %0b want %0b at %0t", wr_drop, m_drop, $time);
    end
  endtask

  task automatic check_reads();
    logic [AW-1:0] a;
    logic [DW-1:0] e;
    #1;
    for (int p = 0; p < NR; p++) begin
      a = raddr[p*AW +: AW];
      e = exp_read(a);
      total++;
      if (rdata[p*DW +: DW] !== e) begin
        bad++;
        $display("FAIL read p%0d addr %0d: got %h want %h at %0t", p, a, rdata[p*DW +: DW], e, $time);
      end
    end
  endtask

  task automatic check_all();
    we = 1'b0;
    for (int a = 0; a < N; a++) begin
      raddr[AW-1:0]    = AW'(a);
      raddr[2*AW-1:AW] = AW'(N - 1 - a);
      check_reads();
    end
  endtask

  task automatic write_one(input logic [AW-1:0] a, input logic [DW-1:0] d);
    we = 1'b1; waddr = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    #2;
    total++;
    if (busy !== 1'b0 || clr_done !== 1'b0 || wr_drop !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags: got busy=%0b done=%0b drop=%0b want 0 0 0", busy, clr_done, wr_drop);
    end
    check_all();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    write_one(5'd3, 32'hDEADBEEF);
    raddr = {5'd0, 5'd3};
    #1;
    total++;
    if (rdata[DW-1:0] !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL basic_rd0: got %h want deadbeef", rdata[DW-1:0]);
    end
    total++;
    if (rdata[2*DW-1:DW] !== 32'h0) begin
      bad++;
      $display("FAIL basic_rd1: got %h want 0", rdata[2*DW-1:DW]);
    end
    check_reads();
  endtask

  task automatic test_bypass();
    logic [DW-1:0] old_v;
    logic [DW-1:0] e;
    old_v = m_mem[5];
    we = 1'b1; waddr = 5'd5; wdata = 32'h12345678;
    raddr = {5'd0, 5'd5};
    #1;
`ifdef REGFILE_BYPASS_EN
    e = 32'h12345678;
`else
    e = old_v;
`endif
    total++;
    if (rdata[DW-1:0] !== e) begin
      bad++;
      $display("FAIL bypass_same_cycle: got %h want %h", rdata[DW-1:0], e);
    end
    tick();
    we = 1'b0;
    #1;
    total++;
    if (rdata[DW-1:0] !== 32'h12345678) begin
      bad++;
      $display("FAIL bypass_after_edge: got %h want 12345678", rdata[DW-1:0]);
    end
  endtask

  task automatic test_clear();
    int busy_cnt = 0;
    int done_cnt = 0;
    int drop_cnt = 0;
    for (int a = 1; a < N; a++) write_one(AW'(a), $urandom | 32'h1);
    // Write coinciding with clr_req must land and then be swept.
    we = 1'b1; waddr = 5'd9; wdata = 32'hCAFEF00D; clr_req = 1'b1;
    tick();
    we = 1'b0; clr_req = 1'b0;
    if (busy === 1'b1) busy_cnt++;
    for (int i = 0; i < 40; i++) begin
      clr_req = (i == 5);
      if (i == 8) begin
        we = 1'b1; waddr = 5'd31; wdata = 32'hA5A5A5A5;
      end else begin
        we = 1'b0;
      end
      raddr = {AW'($urandom_range(0, N-1)), AW'($urandom_range(0, N-1))};
      check_reads();
      tick();
      if (busy === 1'b1) busy_cnt++;
      if (clr_done === 1'b1) done_cnt++;
      if (wr_drop === 1'b1) drop_cnt++;
    end
    clr_req = 1'b0; we = 1'b0;
    total++;
    if (busy_cnt != 32) begin
      bad++;
      $display("FAIL sweep_len: got %0d want 32", busy_cnt);
    end
    total++;
    if (done_cnt != 1) begin
      bad++;
      $display("FAIL done_pulses: got %0d want 1", done_cnt);
    end
    total++;
    if (drop_cnt != 1) begin
      bad++;
      $display("FAIL drop_pulses: got %0d want 1", drop_cnt);
    end
    check_all();
  endtask

  task automatic test_reset_mid_sweep();
    int done_cnt = 0;
    for (int a = 1; a < 8; a++) write_one(AW'(a), $urandom | 32'h1);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    reset = 1'b1;
    model_reset();
    #1;
    total++;
    if (busy !== 1'b0 || clr_done !== 1'b0 || wr_drop !== 1'b0) begin
      bad++;
      $display("FAIL abort_flags: got busy=%0b done=%0b drop=%0b want 0 0 0", busy, clr_done, wr_drop);
    end
    check_all();
    @(negedge clk);
    reset = 1'b0;
    write_one(5'd7, 32'h0BADC0DE);
    raddr = {5'd1, 5'd7};
    check_reads();
    total++;
    if (rdata[DW-1:0] !== 32'h0BADC0DE) begin
      bad++;
      $display("FAIL post_reset_write: got %h want 0badc0de", rdata[DW-1:0]);
    end
    for (int i = 0; i < 30; i++) begin
      tick();
      if (clr_done === 1'b1) done_cnt++;
    end
    total++;
    if (done_cnt != 0) begin
      bad++;
      $display("FAIL abort_done: got %0d pulses want 0", done_cnt);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      we      = 1'($urandom_range(0, 1));
      waddr   = AW'($urandom_range(0, N-1));
      wdata   = $urandom;
      raddr   = {AW'($urandom_range(0, N-1)), AW'($urandom_range(0, N-1))};
      clr_req = ($urandom_range(0, 40) == 0);
      check_reads();
      tick();
    end
    we = 1'b0; clr_req = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    check_all();
  endtask

  task automatic test_wide_ports();
    logic [AW4-1:0] a;
    logic [DW4-1:0] e;
    for (int k = 1; k < 8; k++) begin
      we4 = 1'b1; waddr4 = AW4'(k);
      wdata4 = DW4'((k << 12) | $urandom_range(0, 4095));
      tick();
    end
    we4 = 1'b0;
    for (int t = 0; t < 8; t++) begin
      if (t == 0) raddr4 = {3'd7, 3'd0, 3'd5, 3'd2};
      else raddr4 = NR4*AW4'($urandom_range(0, 4095));
      #1;
      for (int p = 0; p < NR4; p++) begin
        a = raddr4[p*AW4 +: AW4];
        e = (a == 0) ? '0 : m4[a];
        total++;
        if (rdata4[p*DW4 +: DW4] !== e) begin
          bad++;
          $display("FAIL wide_p%0d addr %0d: got %h want %h", p, a, rdata4[p*DW4 +: DW4], e);
        end
      end
    end
    total++;
    if (busy4 !== 1'b0 || clr_done4 !== 1'b0 || wr_drop4 !== 1'b0) begin
      bad++;
      $display("FAIL wide_flags: got busy=%0b done=%0b drop=%0b want 0 0 0", busy4, clr_done4, wr_drop4);
    end
  endtask

  initial begin
    reset = 1'b1;
    we = 1'b0; waddr = '0; wdata = '0; raddr = '0; clr_req = 1'b0;
    we4 = 1'b0; waddr4 = '0; wdata4 = '0; raddr4 = '0; clr_req4 = 1'b0;
    model_reset();
    #12;
    test_reset();
    test_basic();
    test_bypass();
    test_clear();
    test_reset_mid_sweep();
    test_random();
    test_wide_ports();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
